// File: rtl/dm_loader_pkg.sv
// Shared constants and state encodings for the boot-time data-memory loader.
// No logic; imported by dm_loader and anything that needs the memory depth.
// Depth must stay below 255 so an oversize count is still expressible in one byte.
package dm_loader_pkg;

    // Number of 16-bit words in data memory.
    localparam int LD_MEM_SIZE = 128;

    typedef enum logic [2:0] {
        LD_S_CNT  = 3'd0,
        LD_S_HI   = 3'd1,
        LD_S_LO   = 3'd2,
        LD_S_SUM  = 3'd3,
        LD_S_DONE = 3'd4,
        LD_S_ERR  = 3'd5
    } ld_state_t;

endpackage

// File: rtl/dm_loader.sv
// Boot loader: parses count / big-endian words / XOR checksum, writes one word per pair of bytes.
// Latency: write registered one cycle after the low byte; done/err one cycle after the checksum byte.
// Backpressure: accepts a byte every cycle while loading; in_ready drops once done/err or during reset.
module dm_loader
    import dm_loader_pkg::*;
#(
    parameter int MEM_SIZE = LD_MEM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_din,
    output logic        dm_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    ld_state_t  state;
    ld_state_t  state_nxt;
    logic [7:0] hi_byte;
    logic [7:0] word_cnt;
    logic [7:0] word_total;
    logic [7:0] acc;
    logic       active;
    logic       xfer;
    logic       last_word;
    logic       oversize;

    assign active    = (state != LD_S_DONE) && (state != LD_S_ERR);
    assign in_ready  = active && !reset;
    assign xfer      = in_valid && in_ready;
    assign busy      = active;
    assign done      = (state == LD_S_DONE);
    assign err       = (state == LD_S_ERR);
    assign last_word = (word_cnt == (word_total - 8'd1));
    assign oversize  = int'({24'd0, in_data}) > MEM_SIZE;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LD_S_CNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; only advances on an accepted byte.
    always_comb begin
        state_nxt = state;
        case (state)
            LD_S_CNT: begin
                if (xfer) begin
                    if (in_data == 8'd0) begin
                        state_nxt = LD_S_SUM;
                    end else if (oversize) begin
                        state_nxt = LD_S_ERR;
                    end else begin
                        state_nxt = LD_S_HI;
                    end
                end
            end
            LD_S_HI: begin
                if (xfer) begin
                    state_nxt = LD_S_LO;
                end
            end
            LD_S_LO: begin
                if (xfer) begin
                    state_nxt = last_word ? LD_S_SUM : LD_S_HI;
                end
            end
            LD_S_SUM: begin
                if (xfer) begin
                    state_nxt = (in_data == acc) ? LD_S_DONE : LD_S_ERR;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Datapath: byte latch, word counter, running XOR and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte    <= 8'd0;
            word_cnt   <= 8'd0;
            word_total <= 8'd0;
            acc        <= 8'd0;
            dm_we      <= 1'b0;
            dm_addr    <= 16'd0;
            dm_din     <= 16'd0;
        end else begin
            dm_we <= 1'b0;
            case (state)
                LD_S_CNT: begin
                    // Accumulator starts from zero, so after the count byte it equals N.
                    acc      <= xfer ? in_data : 8'd0;
                    word_cnt <= 8'd0;
                    if (xfer) begin
                        word_total <= in_data;
                    end
                end
                LD_S_HI: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        acc     <= acc ^ in_data;
                    end
                end
                LD_S_LO: begin
                    if (xfer) begin
                        acc      <= acc ^ in_data;
                        dm_we    <= 1'b1;
                        dm_addr  <= {8'd0, word_cnt};
                        dm_din   <= {hi_byte, in_data};
                        word_cnt <= word_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_loader.sv
// Directed bench for dm_loader: framed streams, checksum error, empty and oversize frames,
// gapped stream and mid-frame reset. Writes are captured into a local memory image.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_dm_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dm_addr;
    logic [15:0] dm_din;
    logic        dm_we;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int we_cycles = 0;
    logic [15:0] mem [0:255];

    dm_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_we    (dm_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Memory image: dm_we is high for a whole cycle, so the falling edge sees each write once.
    always @(negedge clk) begin
        if (dm_we) begin
            mem[dm_addr[7:0]] = dm_din;
            we_cycles = we_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        we_cycles = 0;
    endtask

    // Present one byte for one cycle; returns just after the rising edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    // Leave in_valid low for g cycles before the next send.
    task automatic gap(input int g);
        if (g > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (g - 1) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_we_dropped", {31'd0, dm_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_we", {31'd0, dm_we}, 32'd0);
        check("reset_addr", {16'd0, dm_addr}, 32'h0000);
        check("reset_din", {16'd0, dm_din}, 32'h0000);

        // Scenario 1: back-to-back good frame.
        send(8'h02);
        send(8'h12);
        send(8'h34);
        check("s1_we0", {31'd0, dm_we}, 32'd1);
        check("s1_addr0", {16'd0, dm_addr}, 32'h0000);
        check("s1_din0", {16'd0, dm_din}, 32'h1234);
        send(8'hAB);
        check("s1_we_one_cycle", {31'd0, dm_we}, 32'd0);
        check("s1_din_hold", {16'd0, dm_din}, 32'h1234);
        send(8'hCD);
        check("s1_we1", {31'd0, dm_we}, 32'd1);
        check("s1_addr1", {16'd0, dm_addr}, 32'h0001);
        check("s1_din1", {16'd0, dm_din}, 32'hABCD);
        send(8'h42);
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_err", {31'd0, err}, 32'd0);
        check("s1_busy", {31'd0, busy}, 32'd0);
        check("s1_in_ready", {31'd0, in_ready}, 32'd0);
        send(8'h01);
        send(8'h99);
        send(8'h99);
        gap(2);
        check("s1_mem0", {16'd0, mem[0]}, 32'h1234);
        check("s1_mem1", {16'd0, mem[1]}, 32'hABCD);
        check("s1_we_cycles", we_cycles, 32'd2);
        check("s1_done_sticky", {31'd0, done}, 32'd1);

        // Scenario 2: bad checksum still writes both words.
        do_reset();
        clear_model();
        send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h43);
        check("s2_err", {31'd0, err}, 32'd1);
        check("s2_done", {31'd0, done}, 32'd0);
        check("s2_in_ready", {31'd0, in_ready}, 32'd0);
        gap(2);
        check("s2_mem0", {16'd0, mem[0]}, 32'h1234);
        check("s2_mem1", {16'd0, mem[1]}, 32'hABCD);
        check("s2_we_cycles", we_cycles, 32'd2);

        // Scenario 3: empty frame.
        do_reset();
        clear_model();
        send(8'h00);
        check("s3_busy_mid", {31'd0, busy}, 32'd1);
        check("s3_done_mid", {31'd0, done}, 32'd0);
        send(8'h00);
        check("s3_done", {31'd0, done}, 32'd1);
        check("s3_err", {31'd0, err}, 32'd0);
        gap(2);
        check("s3_we_cycles", we_cycles, 32'd0);

        // Scenario 4: count one above the memory size.
        do_reset();
        clear_model();
        send(8'h81);
        check("s4_err", {31'd0, err}, 32'd1);
        check("s4_in_ready", {31'd0, in_ready}, 32'd0);
        send(8'h01); send(8'h55); send(8'h55); send(8'h01);
        gap(2);
        check("s4_we_cycles", we_cycles, 32'd0);
        check("s4_err_sticky", {31'd0, err}, 32'd1);
        check("s4_done", {31'd0, done}, 32'd0);

        // Scenario 5: good frame with random idle gaps.
        do_reset();
        clear_model();
        gap($urandom_range(0, 5)); send(8'h02);
        gap($urandom_range(0, 5)); send(8'h12);
        gap($urandom_range(0, 5)); send(8'h34);
        gap($urandom_range(0, 5)); send(8'hAB);
        gap($urandom_range(0, 5)); send(8'hCD);
        gap($urandom_range(0, 5)); send(8'h42);
        check("s5_done", {31'd0, done}, 32'd1);
        check("s5_err", {31'd0, err}, 32'd0);
        gap(2);
        check("s5_mem0", {16'd0, mem[0]}, 32'h1234);
        check("s5_mem1", {16'd0, mem[1]}, 32'hABCD);
        check("s5_we_cycles", we_cycles, 32'd2);

        // Scenario 6: reset mid-frame, then a fresh one-word frame.
        do_reset();
        clear_model();
        send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
        gap(1);
        check("s6_mem0_partial", {16'd0, mem[0]}, 32'h1234);
        do_reset();
        check("s6_busy_after_rst", {31'd0, busy}, 32'd1);
        check("s6_done_after_rst", {31'd0, done}, 32'd0);
        send(8'h01); send(8'h55); send(8'h55);
        check("s6_addr", {16'd0, dm_addr}, 32'h0000);
        check("s6_din", {16'd0, dm_din}, 32'h5555);
        send(8'h01);
        check("s6_done", {31'd0, done}, 32'd1);
        check("s6_err", {31'd0, err}, 32'd0);
        gap(2);
        check("s6_mem0", {16'd0, mem[0]}, 32'h5555);
        check("s6_mem1_untouched", {16'd0, mem[1]}, 32'hDEAD);
        check("s6_we_cycles", we_cycles, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
